// File: rtl/cons_check_pkg.sv
// cons_check_pkg: shared types and the slot evaluation function for the
// sequential constraint checker (cons_check_seq and cons_check_lane).
// Slot fields are sized for the widest supported build (VAR_W <= 64,
// NUM_VARS <= 256); narrower builds leave the upper bits constant zero.
package cons_check_pkg;

  localparam int MAX_VAR_W = 64;
  localparam int MAX_SEL_W = 8;

  typedef enum logic [2:0] {
    OP_ADD_OR = 3'd0,  // (A + imm) | B
    OP_XOR    = 3'd1,  // A ^ B
    OP_LAND   = 3'd2,  // A && B
    OP_NEQ    = 3'd3,  // A != B
    OP_IMPL   = 3'd4,  // !A || B
    OP_SUB    = 3'd5,  // A - imm
    OP_SHR    = 3'd6,  // A >> imm[4:0]
    OP_AND    = 3'd7   // A & B
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic                 en;
    op_e                  op;
    logic [MAX_SEL_W-1:0] a_sel;
    logic [MAX_SEL_W-1:0] b_sel;
    logic [MAX_VAR_W-1:0] imm;
  } slot_t;

  localparam slot_t SLOT_RESET = '{
    en:    1'b0,
    op:    OP_ADD_OR,
    a_sel: {MAX_SEL_W{1'b0}},
    b_sel: {MAX_SEL_W{1'b0}},
    imm:   {MAX_VAR_W{1'b0}}
  };

  // Evaluates one slot: the result is computed modulo 2^var_w and the slot
  // is true when that result is nonzero.
  function automatic logic eval_slot(
    input op_e                  op,
    input logic [MAX_VAR_W-1:0] a_in,
    input logic [MAX_VAR_W-1:0] b_in,
    input logic [MAX_VAR_W-1:0] imm_in,
    input int unsigned          var_w
  );
    logic [MAX_VAR_W-1:0] mask;
    logic [MAX_VAR_W-1:0] a;
    logic [MAX_VAR_W-1:0] b;
    logic [MAX_VAR_W-1:0] imm;
    logic [MAX_VAR_W-1:0] res;
    if (var_w >= MAX_VAR_W) begin
      mask = {MAX_VAR_W{1'b1}};
    end else begin
      mask = (64'd1 << var_w) - 64'd1;
    end
    a   = a_in & mask;
    b   = b_in & mask;
    imm = imm_in & mask;
    case (op)
      OP_ADD_OR: res = ((a + imm) & mask) | b;
      OP_XOR:    res = a ^ b;
      OP_LAND:   res = MAX_VAR_W'((|a) && (|b));
      OP_NEQ:    res = MAX_VAR_W'(a != b);
      OP_IMPL:   res = MAX_VAR_W'(!(|a) || (|b));
      OP_SUB:    res = (a - imm) & mask;
      OP_SHR:    res = a >> imm[4:0];
      OP_AND:    res = a & b;
      default:   res = {MAX_VAR_W{1'b0}};
    endcase
    return |(res & mask);
  endfunction

endpackage

// File: rtl/cons_check_lane.sv
// cons_check_lane: combinational evaluator for a single constraint slot.
// Selects operands A and B from the captured variable vector and reports
// whether the slot holds; a disabled slot always holds.
module cons_check_lane
  import cons_check_pkg::*;
#(
  parameter int NUM_VARS = 8,
  parameter int VAR_W    = 32
) (
  input  slot_t                       slot,
  input  logic [NUM_VARS*VAR_W-1:0]   vars,
  output logic                        is_true
);

  logic [MAX_VAR_W-1:0] a_val_s;
  logic [MAX_VAR_W-1:0] b_val_s;

  // Operand muxes: pick variables a_sel and b_sel, zero-extended.
  always_comb begin
    a_val_s = {MAX_VAR_W{1'b0}};
    b_val_s = {MAX_VAR_W{1'b0}};
    for (int i = 0; i < NUM_VARS; i++) begin
      a_val_s = (slot.a_sel == MAX_SEL_W'(i)) ? MAX_VAR_W'(vars[i*VAR_W +: VAR_W]) : a_val_s;
      b_val_s = (slot.b_sel == MAX_SEL_W'(i)) ? MAX_VAR_W'(vars[i*VAR_W +: VAR_W]) : b_val_s;
    end
  end

  // Slot truth: disabled slots are vacuously true.
  always_comb begin
    if (!slot.en) begin
      is_true = 1'b1;
    end else begin
      is_true = eval_slot(slot.op, a_val_s, b_val_s, slot.imm, VAR_W);
    end
  end

endmodule

// File: rtl/cons_check_seq.sv
// cons_check_seq: sequential, runtime-programmable constraint checker.
// A candidate is captured in IDLE, LANES slots are evaluated per cycle in
// EVAL, and the verdict is held in DONE until the consumer takes it.
// Optional build macro: CONS_CHECK_EARLY_ABORT_EN -- leave EVAL at the end
// of the first group that contains a failing slot (same reported result,
// shorter latency). Undefined: every group is evaluated, fixed latency.
module cons_check_seq
  import cons_check_pkg::*;
#(
  parameter int NUM_VARS = 8,
  parameter int VAR_W    = 32,
  parameter int NUM_CONS = 32,
  parameter int LANES    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  output logic                          cfg_ready,
  input  logic [$clog2(NUM_CONS)-1:0]   cfg_idx,
  input  logic                          cfg_en,
  input  logic [2:0]                    cfg_op,
  input  logic [$clog2(NUM_VARS)-1:0]   cfg_a_sel,
  input  logic [$clog2(NUM_VARS)-1:0]   cfg_b_sel,
  input  logic [VAR_W-1:0]              cfg_imm,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_VARS*VAR_W-1:0]     in_vars,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sat,
  output logic [$clog2(NUM_CONS)-1:0]   out_fail_idx,
  output logic [CNT_W-1:0]              sat_count
);

  localparam int IDX_W   = $clog2(NUM_CONS);
  localparam int NUM_GRP = NUM_CONS / LANES;
  localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int VARS_W  = NUM_VARS * VAR_W;

  // Registered state
  state_e              state_r;
  logic [GRP_W-1:0]    grp_r;
  logic                fail_r;
  logic [IDX_W-1:0]    fail_idx_r;
  logic [VARS_W-1:0]   vars_r;
  slot_t               slots_r [NUM_CONS];
  logic                in_ready_r;
  logic                cfg_ready_r;
  logic                out_valid_r;
  logic                out_sat_r;
  logic [IDX_W-1:0]    out_fail_idx_r;
  logic [CNT_W-1:0]    sat_count_r;

  // Combinational helpers
  slot_t               lane_slot_s [LANES];
  logic [IDX_W-1:0]    lane_idx_s  [LANES];
  logic [LANES-1:0]    lane_true_s;
  logic                grp_fail_s;
  logic [IDX_W-1:0]    grp_fail_idx_s;
  logic                eval_fail_s;
  logic [IDX_W-1:0]    eval_idx_s;
  logic                eval_last_s;
  logic                eval_stop_s;
  logic                cfg_take_s;
  slot_t               cfg_slot_s;

  // Route the current group's slots to the lanes.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx_s[l]  = IDX_W'(int'(grp_r) * LANES + l);
      lane_slot_s[l] = slots_r[lane_idx_s[l]];
    end
  end

  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
    cons_check_lane #(
      .NUM_VARS (NUM_VARS),
      .VAR_W    (VAR_W)
    ) u_lane (
      .slot    (lane_slot_s[gl]),
      .vars    (vars_r),
      .is_true (lane_true_s[gl])
    );
  end

  // Lowest failing lane of the group: scan high-to-low so the lowest wins.
  always_comb begin
    grp_fail_s     = 1'b0;
    grp_fail_idx_s = {IDX_W{1'b0}};
    for (int l = LANES - 1; l >= 0; l--) begin
      if (!lane_true_s[l]) begin
        grp_fail_s     = 1'b1;
        grp_fail_idx_s = lane_idx_s[l];
      end else begin
        grp_fail_idx_s = grp_fail_idx_s;
      end
    end
  end

  // Verdict so far, keeping the first recorded failure, and exit condition.
  always_comb begin
    eval_fail_s = fail_r | grp_fail_s;
    if (fail_r) begin
      eval_idx_s = fail_idx_r;
    end else if (grp_fail_s) begin
      eval_idx_s = grp_fail_idx_s;
    end else begin
      eval_idx_s = {IDX_W{1'b0}};
    end
    eval_last_s = (grp_r == GRP_W'(NUM_GRP - 1));
`ifdef CONS_CHECK_EARLY_ABORT_EN
    eval_stop_s = eval_last_s | grp_fail_s;
`else
    eval_stop_s = eval_last_s;
`endif
  end

  // Config write decode: only in IDLE and only for existing slots.
  always_comb begin
    cfg_take_s       = cfg_we & cfg_ready_r &
                       ({1'b0, cfg_idx} < (IDX_W + 1)'(NUM_CONS));
    cfg_slot_s       = SLOT_RESET;
    cfg_slot_s.en    = cfg_en;
    cfg_slot_s.op    = op_e'(cfg_op);
    cfg_slot_s.a_sel = MAX_SEL_W'(cfg_a_sel);
    cfg_slot_s.b_sel = MAX_SEL_W'(cfg_b_sel);
    cfg_slot_s.imm   = MAX_VAR_W'(cfg_imm);
  end

  // Control FSM with slot storage and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      grp_r          <= {GRP_W{1'b0}};
      fail_r         <= 1'b0;
      fail_idx_r     <= {IDX_W{1'b0}};
      vars_r         <= {VARS_W{1'b0}};
      in_ready_r     <= 1'b1;
      cfg_ready_r    <= 1'b1;
      out_valid_r    <= 1'b0;
      out_sat_r      <= 1'b0;
      out_fail_idx_r <= {IDX_W{1'b0}};
      sat_count_r    <= {CNT_W{1'b0}};
      for (int i = 0; i < NUM_CONS; i++) begin
        slots_r[i] <= SLOT_RESET;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cfg_take_s) begin
            slots_r[cfg_idx] <= cfg_slot_s;
          end
          if (in_valid) begin
            vars_r      <= in_vars;
            grp_r       <= {GRP_W{1'b0}};
            fail_r      <= 1'b0;
            fail_idx_r  <= {IDX_W{1'b0}};
            in_ready_r  <= 1'b0;
            cfg_ready_r <= 1'b0;
            state_r     <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (grp_fail_s && !fail_r) begin
            fail_r     <= 1'b1;
            fail_idx_r <= grp_fail_idx_s;
          end
          if (eval_stop_s) begin
            out_valid_r    <= 1'b1;
            out_sat_r      <= ~eval_fail_s;
            out_fail_idx_r <= eval_idx_s;
            state_r        <= ST_DONE;
          end else begin
            grp_r <= grp_r + GRP_W'(1);
          end
        end
        ST_DONE: begin
          // Result holds until taken; a same-cycle in_valid waits for IDLE.
          if (out_ready) begin
            if (out_sat_r && (sat_count_r != {CNT_W{1'b1}})) begin
              sat_count_r <= sat_count_r + CNT_W'(1);
            end
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            cfg_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          cfg_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign cfg_ready    = cfg_ready_r;
  assign out_valid    = out_valid_r;
  assign out_sat      = out_sat_r;
  assign out_fail_idx = out_fail_idx_r;
  assign sat_count    = sat_count_r;

endmodule

// File: tb/tb_cons_check_seq.sv
// tb_cons_check_seq: directed-vector bench for cons_check_seq with
// NUM_VARS=4, VAR_W=8, NUM_CONS=6, LANES=2, CNT_W=2. Expected latencies
// follow CONS_CHECK_EARLY_ABORT_EN when it is defined for the build.
module tb_cons_check_seq;

  localparam int NUM_VARS = 4;
  localparam int VAR_W    = 8;
  localparam int NUM_CONS = 6;
  localparam int LANES    = 2;
  localparam int CNT_W    = 2;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic        cfg_ready;
  logic [2:0]  cfg_idx;
  logic        cfg_en;
  logic [2:0]  cfg_op;
  logic [1:0]  cfg_a_sel;
  logic [1:0]  cfg_b_sel;
  logic [7:0]  cfg_imm;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vars;
  logic        out_valid;
  logic        out_ready;
  logic        out_sat;
  logic [2:0]  out_fail_idx;
  logic [1:0]  sat_count;

  int   n_vec;
  int   n_err;
  int   exp_cnt;
  logic exp_sat_last;

  cons_check_seq #(
    .NUM_VARS (NUM_VARS),
    .VAR_W    (VAR_W),
    .NUM_CONS (NUM_CONS),
    .LANES    (LANES),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_ready    (cfg_ready),
    .cfg_idx      (cfg_idx),
    .cfg_en       (cfg_en),
    .cfg_op       (cfg_op),
    .cfg_a_sel    (cfg_a_sel),
    .cfg_b_sel    (cfg_b_sel),
    .cfg_imm      (cfg_imm),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_vars      (in_vars),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sat      (out_sat),
    .out_fail_idx (out_fail_idx),
    .sat_count    (sat_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic sat, input int idx);
    if (sat) return NUM_CONS / LANES;
`ifdef CONS_CHECK_EARLY_ABORT_EN
    return idx / LANES + 1;
`else
    return NUM_CONS / LANES;
`endif
  endfunction

  task automatic cfg_write(input logic [2:0] idx, input logic en, input logic [2:0] op,
                           input logic [1:0] a, input logic [1:0] b, input logic [7:0] imm);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_op = op;
    cfg_a_sel = a; cfg_b_sel = b; cfg_imm = imm;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_vars  = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input logic exp_sat, input int exp_idx);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat(exp_sat, exp_idx)));
    chk({tag, ".sat"}, 32'(out_sat), 32'(exp_sat));
    chk({tag, ".idx"}, 32'(out_fail_idx), 32'(exp_idx));
    exp_sat_last = exp_sat;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (exp_sat_last && exp_cnt < 3) exp_cnt++;
    chk({tag, ".ov_low"}, 32'(out_valid), 32'd0);
    chk({tag, ".cnt"}, 32'(sat_count), 32'(exp_cnt));
  endtask

  task automatic run(input string tag, input logic [31:0] v, input logic exp_sat, input int exp_idx);
    push(tag, v);
    wait_valid(tag, exp_sat, exp_idx);
    handshake(tag);
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_cnt = 0; exp_sat_last = 1'b0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_en = 1'b0; cfg_op = 3'd0;
    cfg_a_sel = 2'd0; cfg_b_sel = 2'd0; cfg_imm = 8'd0;
    in_valid = 1'b0; in_vars = 32'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_sat", 32'(out_sat), 32'd0);
    chk("rst.fail_idx", 32'(out_fail_idx), 32'd0);
    chk("rst.sat_count", 32'(sat_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: empty constraint set is satisfied
    run("t1_empty", 32'h0000_0000, 1'b1, 0);

    // 2: slot0 = var0 ^ var1
    cfg_write(3'd0, 1'b1, 3'd1, 2'd0, 2'd1, 8'h00);
    run("t2_xor_eq", 32'h0000_5A5A, 1'b0, 0);
    run("t2_xor_ne", 32'h0000_5B5A, 1'b1, 0);

    // 3: slot3 = var2 -> var3, slot5 = var0 - 0x10; lowest failure wins
    cfg_write(3'd3, 1'b1, 3'd4, 2'd2, 2'd3, 8'h00);
    cfg_write(3'd5, 1'b1, 3'd5, 2'd0, 2'd0, 8'h10);
    run("t3_lowest", 32'h0001_1110, 1'b0, 3);

    // 4: backpressure; config write in DONE must be dropped
    push("t4_bp", 32'h0101_1110);
    wait_valid("t4_bp", 1'b0, 5);
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_en = 1'b1; cfg_op = 3'd3;
    cfg_a_sel = 2'd0; cfg_b_sel = 2'd0; cfg_imm = 8'h00;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      cfg_we = 1'b0;
      chk("t4_hold.out_valid", 32'(out_valid), 32'd1);
      chk("t4_hold.out_sat", 32'(out_sat), 32'd0);
      chk("t4_hold.fail_idx", 32'(out_fail_idx), 32'd5);
      chk("t4_hold.in_ready", 32'(in_ready), 32'd0);
      chk("t4_hold.cfg_ready", 32'(cfg_ready), 32'd0);
    end
    // Handshake and a new candidate in the same cycle must not chain.
    out_ready = 1'b1; in_vars = 32'h0101_1011; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t4_nochain.out_valid", 32'(out_valid), 32'd0);
    chk("t4_nochain.in_ready", 32'(in_ready), 32'd1);
    chk("t4_nochain.cnt", 32'(sat_count), 32'(exp_cnt));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("t4_dropped", 1'b1, 0);
    handshake("t4_dropped");

    // 5: remaining opcodes, disabled slots, modular arithmetic
    cfg_write(3'd0, 1'b0, 3'd1, 2'd0, 2'd1, 8'h00);
    cfg_write(3'd3, 1'b0, 3'd4, 2'd2, 2'd3, 8'h00);
    cfg_write(3'd5, 1'b0, 3'd5, 2'd0, 2'd0, 8'h10);
    cfg_write(3'd2, 1'b1, 3'd0, 2'd0, 2'd1, 8'hF0);
    run("t5_add_wrap", 32'h0000_0010, 1'b0, 2);
    cfg_write(3'd4, 1'b1, 3'd6, 2'd2, 2'd0, 8'h03);
    run("t5_shr_zero", 32'h0007_0110, 1'b0, 4);
    run("t5_shr_one", 32'h0008_0110, 1'b1, 0);
    cfg_write(3'd1, 1'b1, 3'd2, 2'd2, 2'd3, 8'h00);
    run("t5_land_f", 32'h0008_0110, 1'b0, 1);
    run("t5_land_t", 32'h4008_0110, 1'b1, 0);
    cfg_write(3'd0, 1'b1, 3'd7, 2'd2, 2'd3, 8'h00);
    run("t5_and", 32'h4008_0110, 1'b0, 0);
    cfg_write(3'd0, 1'b1, 3'd3, 2'd0, 2'd1, 8'h00);
    run("t5_neq_f", 32'h4008_1010, 1'b0, 0);
    run("t5_neq_t", 32'h4008_1110, 1'b1, 0);

    // Reset in the middle of an evaluation
    push("t_midrst", 32'h4008_1010);
    rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.cfg_ready", 32'(cfg_ready), 32'd1);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.sat_count", 32'(sat_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    @(posedge clk); #1;

    // 6: slots cleared by reset, sat_count saturates at 3
    for (int k = 0; k < 5; k++) begin
      run("t6_sat", 32'h4008_1010, 1'b1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
